ldpc_bf_decoder: RTL and testbench

Parametrised hard-decision bit-flipping LDPC decoder. It accepts one codeword per Avalon-ST packet as signed soft LLRs and iterates a syndrome check and bit-flip loop against a package-defined parity-check matrix. It streams the corrected bits out as a packet with per-frame iteration count and success status. It sits between the demapper LLR stream and the descrambler, and replaces the fixed-width soft-in decoder slot.

---
 rtl/ldpc_bf_decoder_pkg.sv | 55 +++++
 rtl/ldpc_bf_decoder_if.sv | 43 ++++
 rtl/ldpc_bf_decoder_syndrome.sv | 38 +++
 rtl/ldpc_bf_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_ldpc_bf_decoder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ldpc_bf_decoder_pkg.sv
// ----------------------------------------------------------------------------
// ldpc_pkg
// Shared definitions for the bit-flipping LDPC decoder.
//   PKG_N_BITS / PKG_N_CHK : default codeword length and parity-check count
//   H_MAT                  : parity-check matrix, row c = bits touched by check c
//   state_t                : decoder FSM states
//   popcount               : ones count of a vector up to 32 bits wide
//   iter_w                 : width of an iteration counter (never zero)
// ----------------------------------------------------------------------------
package ldpc_pkg;

    localparam int PKG_N_BITS = 16;
    localparam int PKG_N_CHK  = 8;

    // Every column holds exactly two ones and no two columns share the same
    // pair of rows, so the Tanner graph has no length-4 cycles. A single hard
    // error therefore leaves exactly its own two checks unsatisfied and is the
    // only bit that can reach an unsatisfied count of 2.
    //   col : 0    1    2    3    4    5    6    7
    //   rows: 0,1  2,3  4,5  6,7  0,2  1,3  4,6  5,7
    //   col : 8    9    10   11   12   13   14   15
    //   rows: 0,3  1,2  4,7  5,6  0,4  1,5  2,6  3,7
    localparam logic [PKG_N_CHK-1:0][PKG_N_BITS-1:0] H_MAT = {
        16'h8488,   // row 7
        16'h4848,   // row 6
        16'h2884,   // row 5
        16'h1444,   // row 4
        16'h8122,   // row 3
        16'h4212,   // row 2
        16'h2221,   // row 1
        16'h1111    // row 0
    };

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SYND = 2'd1,
        CHK  = 2'd2,
        OUT  = 2'd3
    } state_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

    // A MAX_ITER of 0 would otherwise give a zero-width counter.
    function automatic int iter_w(input int max_iter);
        return (max_iter > 0) ? $clog2(max_iter + 1) : 1;
    endfunction

endpackage

// File: rtl/ldpc_bf_decoder_if.sv
// ----------------------------------------------------------------------------
// ldpc_bf_decoder_if
// Avalon-ST style input LLR stream and output decoded-bit stream of the
// decoder, plus the frame status side-band.
//   in_*       : codeword LLR stream (one LLR per beat)
//   out_*      : decoded bit stream, OUT_W bits per beat, with iteration count
//                and success flag held for the whole packet
//   frame_err  : one-cycle pulse when an input packet is malformed
// Modports: master = environment (LLR source / bit sink), slave = decoder.
// ----------------------------------------------------------------------------
interface ldpc_bf_decoder_if
    import ldpc_pkg::*;
#(
    parameter int LLR_W  = 6,
    parameter int OUT_W  = 2,
    parameter int ITER_W = iter_w(8)
);
    logic              in_startofpacket;
    logic              in_endofpacket;
    logic              in_valid;
    logic              in_ready;
    logic [LLR_W-1:0]  in_cw_in_data;
    logic              out_startofpacket;
    logic              out_endofpacket;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [ITER_W-1:0] out_iter;
    logic              out_ok;
    logic              frame_err;

    modport master (
        output in_startofpacket, in_endofpacket, in_valid, in_cw_in_data, out_ready,
        input  in_ready, out_startofpacket, out_endofpacket, out_valid, out_data,
               out_iter, out_ok, frame_err
    );

    modport slave (
        input  in_startofpacket, in_endofpacket, in_valid, in_cw_in_data, out_ready,
        output in_ready, out_startofpacket, out_endofpacket, out_valid, out_data,
               out_iter, out_ok, frame_err
    );
endinterface

// File: rtl/ldpc_bf_decoder_syndrome.sv
// ----------------------------------------------------------------------------
// ldpc_syndrome
// Purely combinational check-node stage.
//   x_i     : current hard-decision codeword
//   synd_o  : syndrome, synd_o[c] = parity of (H[c] & x_i)
//   unsat_o : per-bit count of unsatisfied checks that touch that bit
// ----------------------------------------------------------------------------
module ldpc_syndrome
    import ldpc_pkg::*;
#(
    parameter int N_BITS = PKG_N_BITS,
    parameter int N_CHK  = PKG_N_CHK,
    parameter int CNT_W  = $clog2(PKG_N_CHK + 1),
    parameter logic [N_CHK-1:0][N_BITS-1:0] H = H_MAT
) (
    input  logic [N_BITS-1:0]            x_i,
    output logic [N_CHK-1:0]             synd_o,
    output logic [N_BITS-1:0][CNT_W-1:0] unsat_o
);

    genvar gi, gj;

    generate
        for (gi = 0; gi < N_CHK; gi++) begin : g_row
            assign synd_o[gi] = ^(H[gi] & x_i);
        end

        for (gj = 0; gj < N_BITS; gj++) begin : g_col
            // Column gj of H, i.e. the set of checks bit gj participates in.
            logic [N_CHK-1:0] col;
            for (gi = 0; gi < N_CHK; gi++) begin : g_bit
                assign col[gi] = H[gi][gj];
            end
            assign unsat_o[gj] = CNT_W'(popcount(32'(synd_o & col)));
        end
    endgenerate

endmodule

// File: rtl/ldpc_bf_decoder.sv
// ----------------------------------------------------------------------------
// ldpc_bf_decoder
// Hard-decision bit-flipping LDPC decoder. Loads one codeword of signed LLRs,
// keeps only their sign bits, then alternates syndrome evaluation and
// parallel bit flipping until the syndrome clears or MAX_ITER flips have been
// made, and finally streams the corrected bits out.
//   clk_clk       : clock
//   reset_reset_n : synchronous active-low reset
//   st            : stream interface (slave side), see ldpc_bf_decoder_if
// All interface outputs come straight from registers.
// ----------------------------------------------------------------------------
module ldpc_bf_decoder
    import ldpc_pkg::*;
#(
    parameter int LLR_W    = 6,
    parameter int OUT_W    = 2,
    parameter int N_BITS   = PKG_N_BITS,
    parameter int N_CHK    = PKG_N_CHK,
    parameter int MAX_ITER = 8,
    parameter int FLIP_TH  = 2,
    parameter logic [N_CHK-1:0][N_BITS-1:0] H = H_MAT
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    ldpc_bf_decoder_if.slave  st
);

    localparam int N_BEATS = N_BITS / OUT_W;
    localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int ITER_W  = iter_w(MAX_ITER);
    localparam int CNT_W   = $clog2(N_CHK + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_BITS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
    localparam logic [ITER_W-1:0] ITER_LIM  = ITER_W'(MAX_ITER);
    localparam logic [CNT_W-1:0]  TH        = CNT_W'(FLIP_TH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q;
    logic                frame_open_q;
    logic [IDX_W-1:0]    idx_q;
    logic [N_BITS-1:0]   x_q;
    logic [N_CHK-1:0]    synd_q;
    logic [ITER_W-1:0]   iter_q;
    logic [BEAT_W-1:0]   beat_q;

    logic                in_ready_q;
    logic                out_valid_q;
    logic                out_sop_q;
    logic                out_eop_q;
    logic [OUT_W-1:0]    out_data_q;
    logic [ITER_W-1:0]   out_iter_q;
    logic                out_ok_q;
    logic                frame_err_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                        in_fire_d;
    logic                        in_take_d;
    logic [IDX_W-1:0]            wr_idx_d;
    logic                        out_fire_d;
    logic [BEAT_W-1:0]           beat_d;
    logic [N_CHK-1:0]            synd_d;
    logic [N_BITS-1:0][CNT_W-1:0] unsat_d;
    logic [N_BITS-1:0]           flip_d;

    // Only the sign of each LLR is used by a hard-decision decoder.
    logic unused_llr_mag;
    assign unused_llr_mag = ^st.in_cw_in_data[LLR_W-2:0];

    always_comb begin
        in_fire_d  = st.in_valid && in_ready_q;
        // Beats outside an open frame count only if they start a new one.
        in_take_d  = in_fire_d && (st.in_startofpacket || frame_open_q);
        wr_idx_d   = st.in_startofpacket ? '0 : idx_q;
        out_fire_d = out_valid_q && st.out_ready;
        beat_d     = beat_q + 1'b1;
    end

    ldpc_syndrome #(
        .N_BITS (N_BITS),
        .N_CHK  (N_CHK),
        .CNT_W  (CNT_W),
        .H      (H)
    ) u_synd (
        .x_i     (x_q),
        .synd_o  (synd_d),
        .unsat_o (unsat_d)
    );

    // x_q does not change between SYND and CHK, so the live unsatisfied
    // counts in CHK belong to the syndrome registered in SYND.
    genvar gi;
    generate
        for (gi = 0; gi < N_BITS; gi++) begin : g_flip
            assign flip_d[gi] = (unsat_d[gi] >= TH);
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= LOAD;
            frame_open_q <= 1'b0;
            idx_q        <= '0;
            x_q          <= '0;
            synd_q       <= '0;
            iter_q       <= '0;
            beat_q       <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_data_q   <= '0;
            out_iter_q   <= '0;
            out_ok_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    in_ready_q <= 1'b1;
                    if (in_take_d) begin
                        x_q[wr_idx_d] <= st.in_cw_in_data[LLR_W-1];
                        if (st.in_endofpacket && (wr_idx_d == LAST_IDX)) begin
                            state_q      <= SYND;
                            in_ready_q   <= 1'b0;
                            frame_open_q <= 1'b0;
                        end else if (st.in_endofpacket || (wr_idx_d == LAST_IDX)) begin
                            // Short packet, or full length without eop.
                            frame_err_q  <= 1'b1;
                            frame_open_q <= 1'b0;
                        end else begin
                            frame_open_q <= 1'b1;
                            idx_q        <= wr_idx_d + 1'b1;
                        end
                    end
                end

                SYND: begin
                    synd_q  <= synd_d;
                    state_q <= CHK;
                end

                CHK: begin
                    if ((synd_q == '0) || (iter_q == ITER_LIM)) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                        out_sop_q   <= 1'b1;
                        out_eop_q   <= (N_BEATS == 1);
                        beat_q      <= '0;
                        out_data_q  <= x_q[OUT_W-1:0];
                        out_iter_q  <= iter_q;
                        out_ok_q    <= (synd_q == '0);
                    end else begin
                        x_q     <= x_q ^ flip_d;
                        iter_q  <= iter_q + 1'b1;
                        state_q <= SYND;
                    end
                end

                OUT: begin
                    if (out_fire_d) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q     <= LOAD;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_sop_q   <= 1'b0;
                            out_eop_q   <= 1'b0;
                            iter_q      <= '0;
                        end else begin
                            beat_q     <= beat_d;
                            out_data_q <= x_q[int'(beat_d)*OUT_W +: OUT_W];
                            out_sop_q  <= 1'b0;
                            out_eop_q  <= (beat_d == LAST_BEAT);
                        end
                    end
                end

                default: state_q <= LOAD;
            endcase
        end
    end

    assign st.in_ready          = in_ready_q;
    assign st.out_valid         = out_valid_q;
    assign st.out_startofpacket = out_sop_q;
    assign st.out_endofpacket   = out_eop_q;
    assign st.out_data          = out_data_q;
    assign st.out_iter          = out_iter_q;
    assign st.out_ok            = out_ok_q;
    assign st.frame_err         = frame_err_q;

endmodule

// File: tb/tb_ldpc_bf_decoder.sv
// ----------------------------------------------------------------------------
// tb_ldpc_bf_decoder
// Directed bench for ldpc_bf_decoder. dut_a uses MAX_ITER=8, dut_b uses
// MAX_ITER=0 (so it returns the raw hard decisions). sel routes the stimulus
// stream to one of them and selects which outputs are observed.
// ----------------------------------------------------------------------------
module tb_ldpc_bf_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       in_valid, in_sop, in_eop, out_ready;
    logic [5:0] in_data;

    int n_pass;
    int n_total;

    always #5 clk = ~clk;

    ldpc_bf_decoder_if #(.LLR_W(6), .OUT_W(2), .ITER_W(4)) if_a ();
    ldpc_bf_decoder_if #(.LLR_W(6), .OUT_W(2), .ITER_W(1)) if_b ();

    ldpc_bf_decoder #(
        .LLR_W(6), .OUT_W(2), .N_BITS(16), .N_CHK(8), .MAX_ITER(8), .FLIP_TH(2)
    ) dut_a (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .st            (if_a.slave)
    );

    ldpc_bf_decoder #(
        .LLR_W(6), .OUT_W(2), .N_BITS(16), .N_CHK(8), .MAX_ITER(0), .FLIP_TH(2)
    ) dut_b (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .st            (if_b.slave)
    );

    assign if_a.in_valid         = in_valid & ~sel;
    assign if_a.in_startofpacket = in_sop;
    assign if_a.in_endofpacket   = in_eop;
    assign if_a.in_cw_in_data    = in_data;
    assign if_a.out_ready        = out_ready;
    assign if_b.in_valid         = in_valid & sel;
    assign if_b.in_startofpacket = in_sop;
    assign if_b.in_endofpacket   = in_eop;
    assign if_b.in_cw_in_data    = in_data;
    assign if_b.out_ready        = out_ready;

    logic       r_in_ready, r_valid, r_sop, r_eop, r_ok, r_ferr;
    logic [1:0] r_data;
    logic [3:0] r_iter;
    assign r_in_ready = sel ? if_b.in_ready          : if_a.in_ready;
    assign r_valid    = sel ? if_b.out_valid         : if_a.out_valid;
    assign r_sop      = sel ? if_b.out_startofpacket : if_a.out_startofpacket;
    assign r_eop      = sel ? if_b.out_endofpacket   : if_a.out_endofpacket;
    assign r_data     = sel ? if_b.out_data          : if_a.out_data;
    assign r_iter     = sel ? {3'd0, if_b.out_iter}  : if_a.out_iter;
    assign r_ok       = sel ? if_b.out_ok            : if_a.out_ok;
    assign r_ferr     = sel ? if_b.frame_err         : if_a.frame_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, r_in_ready, 1'b0);
        check({tag, "_out_valid"}, r_valid, 1'b0);
        check({tag, "_sop"}, r_sop, 1'b0);
        check({tag, "_eop"}, r_eop, 1'b0);
        check({tag, "_data"}, r_data, 2'b00);
        check({tag, "_iter"}, r_iter, 4'd0);
        check({tag, "_ok"}, r_ok, 1'b0);
        check({tag, "_frame_err"}, r_ferr, 1'b0);
        check({tag, "_b_in_ready"}, if_b.in_ready, 1'b0);
        check({tag, "_b_out_valid"}, if_b.out_valid, 1'b0);
    endtask

    // Present n_beats LLRs: bit i of neg selects -3 (else +20); sop on beat 0,
    // eop on beat eop_at (-1 for none). Returns with the last beat presented.
    task automatic send(input logic [15:0] neg, input int n_beats, input int eop_at);
        int n;
        for (int i = 0; i < n_beats; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sop   = (i == 0);
            in_eop   = (i == eop_at);
            in_data  = neg[i] ? 6'h3D : 6'h14;
            n = 0;
            while (!r_in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("in_ready_on_beat", r_in_ready, 1'b1);
        end
    endtask

    // Wait for the output packet, check latency from the last input beat,
    // then take 8 beats (out_ready alternating 1/0 when toggle is set).
    task automatic recv(input logic [15:0] exp_bits, input int exp_iter, input logic exp_ok,
                        input int exp_lat, input bit toggle);
        int k;
        int beat;
        int cyc;
        logic [1:0] eb;
        k = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
            k++;
        end while (!r_valid && k < 40);
        check("first_valid_latency", k, exp_lat);
        beat = 0;
        cyc  = 0;
        while (beat < 8 && cyc < 60) begin
            if (cyc > 0) @(negedge clk);
            out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            eb = exp_bits[beat*2 +: 2];
            check("out_valid", r_valid, 1'b1);
            check("out_data", r_data, eb);
            check("out_sop", r_sop, (beat == 0));
            check("out_eop", r_eop, (beat == 7));
            check("out_iter", r_iter, exp_iter);
            check("out_ok", r_ok, exp_ok);
            check("in_ready_during_out", r_in_ready, 1'b0);
            $display("beat %0d cyc %0d ready %0b data %b sop %0b eop %0b iter %0d ok %0b",
                     beat, cyc, out_ready, r_data, r_sop, r_eop, r_iter, r_ok);
            if (out_ready) beat++;
            cyc++;
        end
        check("beats_received", beat, 8);
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_after_out", r_in_ready, 1'b1);
        check("valid_after_out", r_valid, 1'b0);
    endtask

    // Idle for a few cycles counting frame_err pulses and output beats.
    task automatic watch_err(input int exp_errs);
        int errs;
        int vseen;
        errs  = 0;
        vseen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
            if (r_ferr)  errs++;
            if (r_valid) vseen++;
        end
        check("frame_err_pulses", errs, exp_errs);
        check("no_output_beats", vseen, 0);
        check("in_ready_after_drop", r_in_ready, 1'b1);
        $display("drop window: frame_err pulses %0d, output beats %0d", errs, vseen);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; sel = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 6'h00;
        out_ready = 1'b1;

        // Reset values, then in_ready one edge after release.
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", r_in_ready, 1'b1);
        check("release_b_in_ready", if_b.in_ready, 1'b1);

        // All-positive codeword: already valid, no flips.
        send(16'h0000, 16, 15);
        recv(16'h0000, 0, 1'b1, 3, 1'b0);

        // Single error on bit 5: one flip corrects it.
        send(16'h0020, 16, 15);
        recv(16'h0000, 1, 1'b1, 5, 1'b0);

        // Same error with MAX_ITER=0: raw bits, failure status.
        sel = 1'b1;
        send(16'h0020, 16, 15);
        recv(16'h0020, 0, 1'b0, 3, 1'b0);

        // Arbitrary pattern on MAX_ITER=0 with out_ready toggling.
        send(16'hB4E1, 16, 15);
        recv(16'hB4E1, 0, 1'b0, 3, 1'b1);
        sel = 1'b0;

        // Early eop on beat 9, then a good frame with an error on bit 12.
        send(16'h0000, 10, 9);
        watch_err(1);
        send(16'h1000, 16, 15);
        recv(16'h0000, 1, 1'b1, 5, 1'b0);

        // Full length without eop.
        send(16'h0000, 16, -1);
        watch_err(1);

        // Stray beat with no open frame is dropped silently.
        @(negedge clk);
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b1; in_data = 6'h3D;
        watch_err(0);

        // sop inside an open frame restarts it without error.
        send(16'hFFFF, 5, -1);
        send(16'h0020, 16, 15);
        recv(16'h0000, 1, 1'b1, 5, 1'b0);

        // Reset during the second SYND of a frame (after one flip).
        send(16'h0020, 16, 15);
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_release_in_ready", r_in_ready, 1'b1);
        send(16'h0020, 16, 15);
        recv(16'h0000, 1, 1'b1, 5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
